// File: rtl/mealy_pattern_detector.sv
// Runtime-programmable serial pattern detector: Mealy match output, registered copy,
// selectable overlap mode and a saturating match counter.
module mealy_pattern_detector #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    input  logic             overlap,
    input  logic             din_valid,
    input  logic             din,
    input  logic             cnt_clr,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       state
);
    localparam int IW = $clog2(PAT_W + 1);
    localparam logic [IW-1:0] LAST = IW'(PAT_W - 1);
    localparam logic [IW-1:0] FULL = IW'(PAT_W);

    typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10} state_t;

    state_t           cur, nxt;
    logic [PAT_W-1:0] pattern;
    logic [PAT_W-2:0] hist;
    logic [IW-1:0]    fill;
    logic [IW-1:0]    bit_idx;
    logic [PAT_W-1:0] cand;

    assign cand  = {hist, din};
    assign state = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= IDLE;
        else     cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE: if (cfg_start) nxt = LOAD;
            LOAD: if (!cfg_start && cfg_valid && bit_idx == LAST) nxt = RUN;
            RUN:  if (cfg_start) nxt = LOAD;
            default: nxt = IDLE;
        endcase
    end

    // cfg_start pre-empts a match so a reload never counts a stale hit
    always_comb begin
        match = (cur == RUN) && din_valid && !cfg_start &&
                (fill >= LAST) && (cand == pattern);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= '0;
            hist    <= '0;
            fill    <= '0;
            bit_idx <= '0;
        end else begin
            case (cur)
                IDLE: if (cfg_start) bit_idx <= '0;
                LOAD: begin
                    if (cfg_start) begin
                        bit_idx <= '0;
                    end else if (cfg_valid) begin
                        pattern <= {pattern[PAT_W-2:0], cfg_bit};
                        bit_idx <= bit_idx + IW'(1);
                        if (bit_idx == LAST) begin
                            hist <= '0;
                            fill <= '0;
                        end
                    end
                end
                RUN: begin
                    if (cfg_start) begin
                        bit_idx <= '0;
                    end else if (din_valid) begin
                        hist <= cand[PAT_W-2:0];
                        // non-overlap: forget history so the next hit needs PAT_W new bits
                        if (match && !overlap) fill <= '0;
                        else if (fill != FULL) fill <= fill + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        match_count <= '0;
        else if (cnt_clr)               match_count <= '0;
        else if (match && !(&match_count)) match_count <= match_count + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) match_q <= 1'b0;
        else     match_q <= match;
    end
endmodule
